// File: rtl/caja_musical_pkg.sv
// ============================================================================
//  Module      : caja_musical_pkg
//  Description : Shared types and constants for the music-box tone path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package caja_musical_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PLAY    = 3'd3,
        ST_GAP     = 3'd4,
        ST_ADVANCE = 3'd5
    } seq_state_t;

    localparam int CLK_HZ_DEF  = 12000000;
    localparam int TICK_HZ_DEF = 1000;

    // Tone half-period divisors at 12 MHz, shared by the ROM and tone generator
    localparam logic [15:0] DIV_C4 = 16'd22933;
    localparam logic [15:0] DIV_E4 = 16'd18202;
    localparam logic [15:0] DIV_G4 = 16'd15306;
    localparam logic [15:0] DIV_A4 = 16'd13636;
    localparam logic [15:0] DIV_C5 = 16'd11467;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/melodia_secuenciador_if.sv
// ============================================================================
//  Module      : melodia_secuenciador_if
//  Description : Control, melody-ROM and tone-generator signals of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface melodia_secuenciador_if #(
    parameter int ADDR_W = 5,
    parameter int DIV_W  = 16,
    parameter int DUR_W  = 10
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DIV_W-1:0]  rom_div;
    logic [DUR_W-1:0]  rom_dur;
    logic [DIV_W-1:0]  tone_div;
    logic              tone_en;
    logic              note_strobe;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop_en, rom_div, rom_dur,
        input  rom_addr, tone_div, tone_en, note_strobe, busy, done
    );

    modport slave (
        input  start, stop, loop_en, rom_div, rom_dur,
        output rom_addr, tone_div, tone_en, note_strobe, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/melodia_secuenciador_tick_gen.sv
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler producing one tick every TICK_DIV cycles after clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 12000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    output logic      tick_o
);
    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/melodia_secuenciador.sv
// ============================================================================
//  Module      : melodia_secuenciador
//  Description : Walks the melody ROM and drives tone divisor/enable per note.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melodia_secuenciador
    import caja_musical_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int TICK_HZ   = TICK_HZ_DEF,
    parameter int ADDR_W    = 5,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 10,
    parameter int GAP_TICKS = 20
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    melodia_secuenciador_if.slave bus
);
    localparam int                TICK_DIV  = tick_div(CLK_HZ, TICK_HZ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_TICKS);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DIV_W-1:0]  tone_div_q, tone_div_d;
    logic              tone_en_q, tone_en_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic              end_of_song;
    logic              tick;
    logic              tick_clr;

    // Every state change restarts the prescaler, so PLAY and GAP start on a clean tick phase
    assign tick_clr = (state_d != state_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            tone_div_q <= '0;
            tone_en_q  <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tone_div_q <= tone_div_d;
            tone_en_q  <= tone_en_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        tone_div_d  = tone_div_q;
        tone_en_d   = tone_en_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        end_of_song = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    rom_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.rom_dur == '0) begin
                    end_of_song = 1'b1;
                end else begin
                    tone_div_d = bus.rom_div;
                    tone_en_d  = (bus.rom_div != '0);
                    cnt_d      = bus.rom_dur;
                    strobe_d   = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (cnt_q <= DUR_W'(1)) begin
                        tone_en_d = 1'b0;
                        if (GAP_TICKS > 0) begin
                            cnt_d   = GAP_LOAD;
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_ADVANCE;
                        end
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                tone_en_d = 1'b0;
                if (tick) begin
                    if (cnt_q <= DUR_W'(1)) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            ST_ADVANCE: begin
                if (rom_addr_q == LAST_ADDR) begin
                    end_of_song = 1'b1;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (end_of_song) begin
            if (bus.loop_en) begin
                rom_addr_d = '0;
                state_d    = ST_FETCH;
            end else begin
                tone_en_d  = 1'b0;
                tone_div_d = '0;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
        end

        // Abort overrides everything, including a same-cycle end of song
        if (bus.stop && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
            tone_div_d = '0;
            tone_en_d  = 1'b0;
            strobe_d   = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.tone_div    = tone_div_q;
    assign bus.tone_en     = tone_en_q;
    assign bus.note_strobe = strobe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

`default_nettype wire
